// File: rtl/pulse_gen.sv
// pulse_gen: windowed pulse-train generator; each tim025 boundary loads a pulse count for the next window.
// Optional PULSE_GEN_SAT_EN clamps the requested count to 250.
`default_nettype none

module pulse_gen #(
  parameter int unsigned HIGH_CYC = 4,
  parameter int unsigned LOW_CYC  = 4
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       tim025,
  input  logic [7:0] data_in,
  output logic       sig_out,
  output logic       busy,
  output logic [7:0] sent_cnt
);

  typedef enum logic [1:0] {
    ARMED = 2'd0,
    HIGH  = 2'd1,
    LOW   = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [7:0] HIGH_LOAD = 8'(HIGH_CYC - 1);
  localparam logic [7:0] LOW_LOAD  = 8'(LOW_CYC - 1);

  state_t     state_q;
  logic       sig_out_q;
  logic       busy_q;
  logic [7:0] sent_cnt_q;
  logic [7:0] sent_q;
  logic [7:0] target_q;
  logic [7:0] remaining_q;
  logic [7:0] phase_q;

  logic [7:0] target_d;
  logic [7:0] sent_d;
  logic       start_ok;

`ifdef PULSE_GEN_SAT_EN
  localparam logic [7:0] SAT_MAX = 8'd250;
  assign target_d = (data_in > SAT_MAX) ? SAT_MAX : data_in;
`else
  assign target_d = data_in;
`endif

  // The target comparison keeps sent from ever passing the loaded count.
  assign start_ok = (remaining_q != 8'd0) && (sent_q < target_q);
  assign sent_d   = sent_q + 8'd1;

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state_q     <= ARMED;
      sig_out_q   <= 1'b0;
      busy_q      <= 1'b0;
      sent_cnt_q  <= 8'd0;
      sent_q      <= 8'd0;
      target_q    <= 8'd0;
      remaining_q <= 8'd0;
      phase_q     <= 8'd0;
    end else if (tim025) begin
      state_q     <= ARMED;
      sig_out_q   <= 1'b0;
      busy_q      <= 1'b0;
      sent_cnt_q  <= sent_q;
      sent_q      <= 8'd0;
      target_q    <= target_d;
      remaining_q <= target_d;
      phase_q     <= 8'd0;
    end else begin
      case (state_q)
        ARMED: begin
          if (start_ok) begin
            state_q   <= HIGH;
            sig_out_q <= 1'b1;
            busy_q    <= 1'b1;
            sent_q    <= sent_d;
            phase_q   <= HIGH_LOAD;
          end else begin
            state_q   <= DONE;
          end
        end
        HIGH: begin
          if (phase_q == 8'd0) begin
            state_q     <= LOW;
            sig_out_q   <= 1'b0;
            remaining_q <= remaining_q - 8'd1;
            phase_q     <= LOW_LOAD;
          end else begin
            phase_q     <= phase_q - 8'd1;
          end
        end
        LOW: begin
          if (phase_q != 8'd0) begin
            phase_q   <= phase_q - 8'd1;
          end else if (start_ok) begin
            state_q   <= HIGH;
            sig_out_q <= 1'b1;
            sent_q    <= sent_d;
            phase_q   <= HIGH_LOAD;
          end else begin
            state_q   <= DONE;
            busy_q    <= 1'b0;
          end
        end
        DONE: begin
          sig_out_q <= 1'b0;
          busy_q    <= 1'b0;
        end
        default: begin
          state_q   <= ARMED;
          sig_out_q <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign sig_out  = sig_out_q;
  assign busy     = busy_q;
  assign sent_cnt = sent_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_pulse_gen.sv
// tb_pulse_gen: scoreboard bench; stimulus queues expected pulses and boundary counts, a monitor pops and compares.
`default_nettype none

module tb_pulse_gen;

  localparam int HC  = 4;
  localparam int LC  = 4;
  localparam int PER = HC + LC;
`ifdef PULSE_GEN_SAT_EN
  localparam int FULL_N = 250;
`else
  localparam int FULL_N = 255;
`endif

  logic       clk_in = 1'b0;
  logic       reset;
  logic       tim025;
  logic [7:0] data_in;
  logic       sig_out;
  logic       busy;
  logic [7:0] sent_cnt;

  always #5 clk_in = ~clk_in;

  pulse_gen #(.HIGH_CYC(HC), .LOW_CYC(LC)) dut (
    .clk_in   (clk_in),
    .reset    (reset),
    .tim025   (tim025),
    .data_in  (data_in),
    .sig_out  (sig_out),
    .busy     (busy),
    .sent_cnt (sent_cnt)
  );

  typedef struct {
    int off;
    int w;
  } pulse_t;

  pulse_t exp_pulse[$];
  int     exp_cnt[$];

  int     n_tests   = 0;
  int     n_fail    = 0;
  int     cyc       = 0;
  bit     b_edge    = 1'b0;
  int     exp_prev  = 0;
  int     win_start = 0;
  bit     hi        = 1'b0;
  int     rise_off  = 0;
  int     width     = 0;
  pulse_t p;
  int     e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(posedge clk_in) begin
    cyc++;
    b_edge = reset && tim025;
  end

  // Monitor: boundary edges report sent_cnt, falling sig_out completes a pulse record.
  always @(negedge clk_in) begin
    if (!reset) begin
      hi    = 1'b0;
      width = 0;
    end else begin
      if (b_edge) begin
        check("cnt_expected", 32'(exp_cnt.size() > 0), 32'd1);
        if (exp_cnt.size() > 0) begin
          e = exp_cnt.pop_front();
          check("sent_cnt", 32'(sent_cnt), 32'(e));
        end
        check("sig_out_at_boundary", 32'(sig_out), 32'd0);
        win_start = cyc;
      end
      if (sig_out && !hi) begin
        hi       = 1'b1;
        rise_off = cyc - win_start;
        width    = 1;
      end else if (sig_out && hi) begin
        width++;
      end else if (!sig_out && hi) begin
        hi = 1'b0;
        check("pulse_expected", 32'(exp_pulse.size() > 0), 32'd1);
        if (exp_pulse.size() > 0) begin
          p = exp_pulse.pop_front();
          check("pulse_offset", 32'(rise_off), 32'(p.off));
          check("pulse_width", 32'(width), 32'(p.w));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk_in);
    #2;
  endtask

  task automatic boundary(input logic [7:0] d, input int nb);
    for (int i = 0; i < nb; i++) begin
      exp_cnt.push_back((i == 0) ? exp_prev : 0);
      data_in = (i == nb - 1) ? d : (d ^ 8'hA5);
      tim025  = 1'b1;
      step();
    end
    tim025 = 1'b0;
  endtask

  task automatic low(input int len, input int n, input int mid_at, input logic [7:0] mid_d);
    int o;
    int w;
    for (int k = 0; k < n; k++) begin
      o = 1 + PER * k;
      w = (len + 1 - o < HC) ? (len + 1 - o) : HC;
      exp_pulse.push_back('{off: o, w: w});
    end
    exp_prev = n;
    for (int i = 1; i <= len; i++) begin
      if (i == mid_at) data_in = mid_d;
      step();
    end
  endtask

  initial begin
    reset   = 1'b0;
    tim025  = 1'b0;
    data_in = 8'd0;
    #3;
    check("reset_sig_out", 32'(sig_out), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_sent_cnt", 32'(sent_cnt), 32'd0);
    step();
    step();
    reset = 1'b1;

    low(20, 0, 0, 8'd0);
    check("busy_before_first_boundary", 32'(busy), 32'd0);

    boundary(8'd5, 1);
    low(200, 5, 0, 8'd0);
    check("busy_done_5", 32'(busy), 32'd0);

    boundary(8'd0, 3);
    low(100, 0, 0, 8'd0);
    check("busy_zero_window", 32'(busy), 32'd0);

    boundary(8'd100, 1);
    low(50, 7, 0, 8'd0);
    check("busy_truncated", 32'(busy), 32'd1);

    boundary(8'd3, 1);
    low(60, 3, 30, 8'd9);

    boundary(8'd9, 1);
    low(80, 9, 0, 8'd0);

    boundary(8'd255, 1);
    low(2100, FULL_N, 0, 8'd0);

    boundary(8'd3, 1);
    step();
    step();
    step();
    check("pre_reset_high", 32'(sig_out), 32'd1);
    reset = 1'b0;
    #1;
    check("async_reset_sig_out", 32'(sig_out), 32'd0);
    check("async_reset_busy", 32'(busy), 32'd0);
    check("async_reset_sent_cnt", 32'(sent_cnt), 32'd0);
    step();
    step();
    reset    = 1'b1;
    exp_prev = 0;
    low(30, 0, 0, 8'd0);
    check("busy_after_reset", 32'(busy), 32'd0);

    boundary(8'd2, 1);
    low(20, 2, 0, 8'd0);

    boundary(8'd0, 1);
    low(5, 0, 0, 8'd0);

    check("pulse_queue_drained", 32'(exp_pulse.size()), 32'd0);
    check("cnt_queue_drained", 32'(exp_cnt.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
